// File: rtl/dds_param_scheduler.sv
// Timed-command scheduler for the DAC phase MAC.
// Commands (timestamp, freq, phase) are buffered in a FIFO. Each one is applied
// to the MAC operand registers once the free-running time counter reaches its
// timestamp. A command whose timestamp has already passed is applied at once
// and recorded as late.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | FIFO empty, nothing to compare
// ST_WAIT  | head command compared against time_now every cycle
// ST_APPLY | popped command loads mac_b/mac_c and restarts mac_a
module dds_param_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIME_W     = 48,
    parameter int LATE_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [TIME_W-1:0]             s_time,
    input  logic [47:0]                   s_freq,
    input  logic [13:0]                   s_phase,
    input  logic                          time_set,
    input  logic [TIME_W-1:0]             time_set_val,
    input  logic                          flush,
    input  logic                          clear_late,
    output logic [TIME_W-1:0]             time_now,
    output logic [TIME_W-1:0]             mac_a,
    output logic [47:0]                   mac_b,
    output logic [13:0]                   mac_c,
    output logic                          update_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          late_flag,
    output logic [LATE_CNT_W-1:0]         late_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_APPLY} state_e;

    state_e                 state_q, state_d;
    logic [TIME_W-1:0]      time_now_q;
    logic [TIME_W-1:0]      mac_a_q;
    logic [47:0]            mac_b_q, pend_freq_q;
    logic [13:0]            mac_c_q, pend_phase_q;
    logic                   update_pulse_q;
    logic                   late_flag_q, late_flag_d;
    logic [LATE_CNT_W-1:0]  late_count_q, late_count_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;

    logic [TIME_W-1:0]      mem_time_q  [FIFO_DEPTH];
    logic [47:0]            mem_freq_q  [FIFO_DEPTH];
    logic [13:0]            mem_phase_q [FIFO_DEPTH];

    logic                   push, pop, late_evt, fifo_empty;
    logic [TIME_W-1:0]      head_time;

    // s_ready depends only on the registered level, never on s_valid
    assign s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = s_valid & s_ready & ~flush;
    assign fifo_empty = (level_q == '0);
    assign head_time  = mem_time_q[rd_ptr_q];

    // Next-state logic: head compare, pop and late detection
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        late_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && (!fifo_empty || push)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush || fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (head_time == time_now_q) begin
                    pop     = 1'b1;
                    state_d = ST_APPLY;
                end else if (head_time < time_now_q) begin
                    pop      = 1'b1;
                    late_evt = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = (!flush && (!fifo_empty || push)) ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Level and late-status next values; a late event beats clear_late
    always_comb begin
        level_d = flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
        late_flag_d  = late_flag_q;
        late_count_d = late_count_q;
        if (late_evt) begin
            late_flag_d = 1'b1;
            if (clear_late)       late_count_d = LATE_CNT_W'(1);
            else if (!(&late_count_q)) late_count_d = late_count_q + LATE_CNT_W'(1);
        end else if (clear_late) begin
            late_flag_d  = 1'b0;
            late_count_d = '0;
        end
    end

    // FIFO storage; contents need no reset since the level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_time_q[wr_ptr_q]  <= s_time;
            mem_freq_q[wr_ptr_q]  <= s_freq;
            mem_phase_q[wr_ptr_q] <= s_phase;
        end
    end

    // Control, time base, FIFO pointers and MAC operand registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            time_now_q     <= '0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            mac_c_q        <= '0;
            pend_freq_q    <= '0;
            pend_phase_q   <= '0;
            update_pulse_q <= 1'b0;
            late_flag_q    <= 1'b0;
            late_count_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
        end else begin
            state_q      <= state_d;
            time_now_q   <= time_set ? time_set_val : time_now_q + TIME_W'(1);
            level_q      <= level_d;
            late_flag_q  <= late_flag_d;
            late_count_q <= late_count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // The head is captured at pop so APPLY does not depend on FIFO state
            if (pop) begin
                pend_freq_q  <= mem_freq_q[rd_ptr_q];
                pend_phase_q <= mem_phase_q[rd_ptr_q];
            end
            update_pulse_q <= (state_q == ST_APPLY);
            if (state_q == ST_APPLY) begin
                mac_a_q <= '0;
                mac_b_q <= pend_freq_q;
                mac_c_q <= pend_phase_q;
            end else begin
                mac_a_q <= mac_a_q + TIME_W'(1);
            end
        end
    end

    assign time_now     = time_now_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_c        = mac_c_q;
    assign update_pulse = update_pulse_q;
    assign fifo_level   = level_q;
    assign late_flag    = late_flag_q;
    assign late_count   = late_count_q;

endmodule

// File: tb/tb_dds_param_scheduler.sv
// Bench for dds_param_scheduler: directed scenarios followed by random traffic,
// all checked every cycle against a timestamp/queue reference model.
module tb_dds_param_scheduler;
    localparam int DEPTH = 16;
    localparam int TW    = 48;
    localparam int LW    = 16;

    logic           clk = 1'b0;
    logic           resetn;
    logic           s_valid, s_ready, time_set, flush, clear_late;
    logic [TW-1:0]  s_time, time_set_val, time_now, mac_a;
    logic [47:0]    s_freq, mac_b;
    logic [13:0]    s_phase, mac_c;
    logic           update_pulse, late_flag;
    logic [4:0]     fifo_level;
    logic [LW-1:0]  late_count;

    dds_param_scheduler #(.FIFO_DEPTH(DEPTH), .TIME_W(TW), .LATE_CNT_W(LW)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_time(s_time), .s_freq(s_freq), .s_phase(s_phase),
        .time_set(time_set), .time_set_val(time_set_val), .flush(flush),
        .clear_late(clear_late), .time_now(time_now), .mac_a(mac_a),
        .mac_b(mac_b), .mac_c(mac_c), .update_pulse(update_pulse),
        .fifo_level(fifo_level), .late_flag(late_flag), .late_count(late_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] t;
        logic [47:0] f;
        logic [13:0] p;
        int          pcyc;
    } cmd_t;

    // Reference model: queued commands plus the cycle of the next allowed compare
    cmd_t        q[$];
    logic [47:0] m_tn, m_a, m_b, pend_f;
    logic [13:0] m_c, pend_p;
    logic        m_pulse, m_flag, pend_v;
    logic [15:0] m_cnt;
    int          cyc, ready_cyc, pend_cyc;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tn = '0; m_a = '0; m_b = '0; m_c = '0;
        m_pulse = 1'b0; m_flag = 1'b0; m_cnt = '0;
        q.delete();
        pend_v = 1'b0;
        ready_cyc = 0;
    endtask

    task automatic check_all();
        chk("time_now",     64'(time_now),     64'(m_tn));
        chk("mac_a",        64'(mac_a),        64'(m_a));
        chk("mac_b",        64'(mac_b),        64'(m_b));
        chk("mac_c",        64'(mac_c),        64'(m_c));
        chk("update_pulse", 64'(update_pulse), 64'(m_pulse));
        chk("fifo_level",   64'(fifo_level),   64'(q.size()));
        chk("s_ready",      64'(s_ready),      64'(q.size() != DEPTH));
        chk("late_flag",    64'(late_flag),    64'(m_flag));
        chk("late_count",   64'(late_count),   64'(m_cnt));
    endtask

    task automatic clear_in();
        s_valid = 1'b0; time_set = 1'b0; flush = 1'b0; clear_late = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, then compare all outputs
    task automatic step();
        logic late_evt;
        logic can_push;
        cmd_t c;
        if (!resetn) begin
            @(posedge clk); #1;
            cyc++;
            model_reset();
            check_all();
            return;
        end
        late_evt = 1'b0;
        can_push = s_valid && (q.size() != DEPTH) && !flush;
        if (!flush && q.size() > 0 && q[0].pcyc < cyc && cyc >= ready_cyc && q[0].t <= m_tn) begin
            late_evt  = (q[0].t < m_tn);
            pend_v    = 1'b1;
            pend_cyc  = cyc + 2;
            pend_f    = q[0].f;
            pend_p    = q[0].p;
            ready_cyc = cyc + 2;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        if (can_push) begin
            c.t = s_time; c.f = s_freq; c.p = s_phase; c.pcyc = cyc;
            q.push_back(c);
        end
        m_tn = time_set ? time_set_val : m_tn + 48'd1;
        if (pend_v && pend_cyc == cyc + 1) begin
            m_a = '0; m_b = pend_f; m_c = pend_p; m_pulse = 1'b1; pend_v = 1'b0;
        end else begin
            m_a = m_a + 48'd1; m_pulse = 1'b0;
        end
        if (late_evt) begin
            m_flag = 1'b1;
            if (clear_late)            m_cnt = 16'd1;
            else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (clear_late) begin
            m_flag = 1'b0; m_cnt = '0;
        end
        @(posedge clk); #1;
        cyc++;
        check_all();
    endtask

    task automatic push_cmd(input logic [47:0] t, input logic [47:0] f, input logic [13:0] p);
        s_valid = 1'b1; s_time = t; s_freq = f; s_phase = p;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        int r;
        resetn = 1'b0;
        clear_in();
        s_time = '0; s_freq = '0; s_phase = '0; time_set_val = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        resetn = 1'b1;

        // Single on-time command
        repeat (5) step();
        push_cmd(48'd100, 48'h1000, 14'h155);
        repeat (96) step();
        chk("t1_time",  64'(time_now),     64'd102);
        chk("t1_pulse", 64'(update_pulse), 64'd1);
        chk("t1_freq",  64'(mac_b),        64'h1000);
        chk("t1_phase", 64'(mac_c),        64'h155);
        chk("t1_maca0", 64'(mac_a),        64'd0);
        chk("t1_late",  64'(late_flag),    64'd0);
        step();
        chk("t1_maca1", 64'(mac_a),        64'd1);

        // Fill the FIFO, 17th push must be refused
        repeat (47) step();
        for (int i = 0; i < 17; i++) begin
            push_cmd(48'd200 + 48'(10 * i), 48'(i + 1), 14'(i));
            if (i == 15) begin
                chk("t2_full_ready", 64'(s_ready),    64'd0);
                chk("t2_full_level", 64'(fifo_level), 64'd16);
            end
        end
        repeat (190) step();
        chk("t2_last_freq", 64'(mac_b),      64'd16);
        chk("t2_empty",     64'(fifo_level), 64'd0);

        // Late command, then clear_late
        time_set = 1'b1; time_set_val = 48'd80;
        step();
        time_set = 1'b0;
        push_cmd(48'd50, 48'h5050, 14'h050);
        repeat (3) step();
        chk("t3_flag",  64'(late_flag),  64'd1);
        chk("t3_count", 64'(late_count), 64'd1);
        chk("t3_freq",  64'(mac_b),      64'h5050);
        clear_late = 1'b1;
        step();
        clear_late = 1'b0;
        chk("t3_clr_flag",  64'(late_flag),  64'd0);
        chk("t3_clr_count", 64'(late_count), 64'd0);

        // Back-to-back timestamps: second one lands in the gap and is late
        time_set = 1'b1; time_set_val = 48'd290;
        step();
        time_set = 1'b0;
        push_cmd(48'd300, 48'hA300, 14'h300);
        push_cmd(48'd301, 48'hA301, 14'h301);
        repeat (15) step();
        chk("t4_count", 64'(late_count), 64'd1);
        chk("t4_freq",  64'(mac_b),      64'hA301);

        // time_set while a command waits
        time_set = 1'b1; time_set_val = 48'd990;
        step();
        time_set = 1'b0;
        push_cmd(48'd1005, 48'hB005, 14'h005);
        repeat (3) step();
        time_set = 1'b1; time_set_val = 48'd1000;
        step();
        time_set = 1'b0;
        repeat (7) step();
        chk("t5_time",  64'(time_now),     64'd1007);
        chk("t5_pulse", 64'(update_pulse), 64'd1);
        chk("t5_freq",  64'(mac_b),        64'hB005);

        // Flush, then reset in the middle of a wait
        for (int i = 0; i < 4; i++) push_cmd(m_tn + 48'd500 + 48'(i), 48'hC000 + 48'(i), 14'(i));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_flush_level", 64'(fifo_level), 64'd0);
        push_cmd(m_tn + 48'd100, 48'hD000, 14'h0D0);
        repeat (3) step();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        resetn = 1'b1;
        repeat (150) step();

        // Random traffic
        for (int k = 0; k < 700; k++) begin
            clear_in();
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b1;
                r = $urandom_range(0, 9);
                if (r < 2) s_time = m_tn - 48'($urandom_range(1, 20));
                else       s_time = m_tn + 48'($urandom_range(1, 30));
                s_freq  = {16'($urandom), 32'($urandom)};
                s_phase = 14'($urandom);
            end
            if ($urandom_range(0, 99) == 0)  flush = 1'b1;
            if ($urandom_range(0, 49) == 0)  clear_late = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
                time_set = 1'b1;
                time_set_val = m_tn + 48'($urandom_range(0, 10));
            end
            step();
        end
        clear_in();
        repeat (60) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
